// File: rtl/cou_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cou_pkg
// Description : Shared mode/state types for the cou up/down counter.
// Revision    : 1.0 - initial release
// ============================================================================
package cou_pkg;

    typedef enum logic [1:0] {
        WRAP    = 2'd0,
        SAT     = 2'd1,
        ONESHOT = 2'd2
    } cou_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cou_state_e;

    // The unused encoding 3 behaves as WRAP.
    function automatic cou_mode_e decode_mode(input logic [1:0] mode);
        case (mode)
            2'd1:    decode_mode = SAT;
            2'd2:    decode_mode = ONESHOT;
            default: decode_mode = WRAP;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cou_limit_detect.sv
`default_nettype none
// ============================================================================
// Module      : cou_limit_detect
// Description : Flags when the count sits on, or is one step from, the
//               terminal value for the current direction.
// Revision    : 1.0 - initial release
// ============================================================================
module cou_limit_detect
    import cou_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_dn,
    output logic             at_term,
    output logic             next_is_term
);

    localparam logic [WIDTH:0] c_max_ext = {1'b0, MAX_VAL};
    localparam logic [WIDTH:0] c_one     = (WIDTH+1)'(1);

    logic [WIDTH:0] w_cnt_ext;
    logic [WIDTH:0] w_inc;
    logic [WIDTH:0] w_dec;

    // One extra bit keeps MAX_VAL = 2**WIDTH-1 from aliasing onto zero.
    assign w_cnt_ext = {1'b0, count};
    assign w_inc     = w_cnt_ext + c_one;
    assign w_dec     = w_cnt_ext - c_one;

    assign at_term      = up_dn ? (count == MAX_VAL) : (count == '0);
    assign next_is_term = up_dn ? (w_inc == c_max_ext) : (w_dec == '0);

endmodule
`default_nettype wire

// File: rtl/cou_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : cou_updown_counter
// Description : Up/down counter with synchronous load, programmable modulo
//               and wrap / saturate / one-shot count modes.
// Revision    : 1.0 - initial release
// ============================================================================
module cou_updown_counter
    import cou_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic             en,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] data_out,
    output logic             tc,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH:0] c_one = (WIDTH+1)'(1);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;
    cou_state_e       r_state;

    logic [WIDTH-1:0] w_count_nxt;
    logic             w_tc_nxt;
    logic             w_ovf_set;
    cou_state_e       w_state_nxt;
    cou_mode_e        w_mode;
    logic             w_count_ok;
    logic             w_at_term;
    logic             w_next_is_term;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic [WIDTH-1:0] w_step;
    logic             w_unused_carry;

    cou_limit_detect #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_limit (
        .count        (r_count),
        .up_dn        (up_dn),
        .at_term      (w_at_term),
        .next_is_term (w_next_is_term)
    );

    assign w_mode         = decode_mode(mode);
    assign w_count_ok     = (w_mode != ONESHOT) || (r_state == RUN);
    assign w_load_val     = (data_in > MAX_VAL) ? MAX_VAL : data_in;
    assign w_inc          = {1'b0, r_count} + c_one;
    assign w_dec          = {1'b0, r_count} - c_one;
    assign w_step         = up_dn ? w_inc[WIDTH-1:0] : w_dec[WIDTH-1:0];
    assign w_unused_carry = w_inc[WIDTH] ^ w_dec[WIDTH];

    // Load beats enable; terminal handling only applies to an enabled step.
    always_comb begin
        w_count_nxt = r_count;
        w_tc_nxt    = 1'b0;
        w_ovf_set   = 1'b0;
        w_state_nxt = r_state;
        if (load) begin
            w_count_nxt = w_load_val;
            w_state_nxt = (w_mode == ONESHOT) ? RUN : IDLE;
        end else begin
            if (w_mode != ONESHOT) begin
                w_state_nxt = IDLE;
            end
            if (en && w_count_ok) begin
                if (!w_at_term) begin
                    w_count_nxt = w_step;
                    w_tc_nxt    = w_next_is_term;
                end else begin
                    case (w_mode)
                        SAT:     w_ovf_set   = 1'b1;
                        ONESHOT: w_state_nxt = DONE;
                        default: begin
                            w_count_nxt = up_dn ? '0 : MAX_VAL;
                            w_ovf_set   = 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_count <= RST_VAL;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
            r_state <= IDLE;
        end else begin
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
            r_ovf   <= w_ovf_set | (r_ovf & ~clr_ovf);
            r_state <= w_state_nxt;
        end
    end

    assign data_out = r_count;
    assign tc       = r_tc;
    assign ovf      = r_ovf;
    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_cou_updown_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_cou_updown_counter
// Description : Directed and randomized checks of two counter instances
//               (full-range and MAX_VAL=10) against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cou_updown_counter;

    localparam int WIDTH = 4;

    logic             clock = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic             load, en, up_dn, clr_ovf;
    logic [1:0]       mode;

    logic [WIDTH-1:0] f_dout, l_dout;
    logic             f_tc, f_ovf, f_busy, f_done;
    logic             l_tc, l_ovf, l_busy, l_done;
    logic [7:0]       fobs, lobs;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int cnt;
        bit tc;
        bit ovf;
        bit run;
        bit fin;
    } mdl_t;

    mdl_t mf, ml;

    always #5 clock = ~clock;

    cou_updown_counter #(.WIDTH(WIDTH), .MAX_VAL(4'd15), .RST_VAL(4'd0)) u_full (
        .clock(clock), .rst(rst), .data_in(data_in), .load(load), .en(en),
        .up_dn(up_dn), .mode(mode), .clr_ovf(clr_ovf), .data_out(f_dout),
        .tc(f_tc), .ovf(f_ovf), .busy(f_busy), .done(f_done)
    );

    cou_updown_counter #(.WIDTH(WIDTH), .MAX_VAL(4'd10), .RST_VAL(4'd0)) u_lim (
        .clock(clock), .rst(rst), .data_in(data_in), .load(load), .en(en),
        .up_dn(up_dn), .mode(mode), .clr_ovf(clr_ovf), .data_out(l_dout),
        .tc(l_tc), .ovf(l_ovf), .busy(l_busy), .done(l_done)
    );

    assign fobs = {f_dout, f_tc, f_ovf, f_busy, f_done};
    assign lobs = {l_dout, l_tc, l_ovf, l_busy, l_done};

    function automatic mdl_t mreset();
        mdl_t s;
        s.cnt = 0; s.tc = 0; s.ovf = 0; s.run = 0; s.fin = 0;
        return s;
    endfunction

    // Next state from the counter rules, using plain integer arithmetic.
    function automatic mdl_t mstep(mdl_t s, int maxv);
        mdl_t n;
        int   term;
        bit   os;
        bit   hit;
        n    = s;
        term = up_dn ? maxv : 0;
        os   = (mode == 2'd2);
        hit  = 0;
        n.tc = 0;
        if (load) begin
            n.cnt = (int'(data_in) > maxv) ? maxv : int'(data_in);
            n.run = os;
            n.fin = 0;
        end else begin
            if (!os) begin
                n.run = 0;
                n.fin = 0;
            end
            if (en && (!os || s.run)) begin
                if (s.cnt != term) begin
                    n.cnt = up_dn ? s.cnt + 1 : s.cnt - 1;
                    n.tc  = (n.cnt == term);
                end else if (mode == 2'd1) begin
                    hit = 1;
                end else if (os) begin
                    n.run = 0;
                    n.fin = 1;
                end else begin
                    n.cnt = up_dn ? 0 : maxv;
                    hit   = 1;
                end
            end
        end
        n.ovf = hit || (s.ovf && !clr_ovf);
        return n;
    endfunction

    function automatic logic [7:0] exp_of(mdl_t s);
        return {4'(s.cnt), s.tc, s.ovf, s.run, s.fin};
    endfunction

    task automatic tick();
        @(posedge clock);
        mf = mstep(mf, 15);
        ml = mstep(ml, 10);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; load = 0; en = 0; up_dn = 1; mode = 2'd0; clr_ovf = 0; data_in = '0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (fobs !== 8'h00) begin n_fail++; $display("FAIL reset_full: got %b want %b", fobs, 8'h00); end
        n_checks++;
        if (lobs !== 8'h00) begin n_fail++; $display("FAIL reset_lim: got %b want %b", lobs, 8'h00); end
        rst = 1'b1;
        mf = mreset(); ml = mreset();
        load = 1; data_in = 4'd8; en = 1;
        tick();
        load = 0;
        tick();
        n_checks++;
        if (f_dout !== 4'd9) begin n_fail++; $display("FAIL midcount_pre: got %0d want 9", f_dout); end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (fobs !== 8'h00) begin n_fail++; $display("FAIL reset_async: got %b want %b", fobs, 8'h00); end
        @(posedge clock);
        #1;
        n_checks++;
        if (fobs !== 8'h00 || lobs !== 8'h00)
            begin n_fail++; $display("FAIL reset_held: got %b/%b want 0/0", fobs, lobs); end
        rst = 1'b1;
        en = 0;
        mf = mreset(); ml = mreset();
    endtask

    task automatic test_wrap();
        logic [7:0] want [3];
        want = '{8'b1111_1000, 8'b0000_0100, 8'b0001_0100};
        mode = 2'd0; up_dn = 1; en = 0; clr_ovf = 0; load = 1; data_in = 4'd14;
        tick();
        n_checks++;
        if (f_dout !== 4'd14) begin n_fail++; $display("FAIL wrap_load: got %0d want 14", f_dout); end
        load = 0; en = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (fobs !== want[i]) begin n_fail++; $display("FAIL wrap_full step %0d: got %b want %b", i, fobs, want[i]); end
            n_checks++;
            if (lobs !== exp_of(ml)) begin n_fail++; $display("FAIL wrap_lim step %0d: got %b want %b", i, lobs, exp_of(ml)); end
        end
    endtask

    task automatic test_sat();
        logic [7:0] want [3];
        want = '{8'b0000_1000, 8'b0000_0100, 8'b0000_0100};
        mode = 2'd1; up_dn = 0; en = 0; clr_ovf = 1; load = 1; data_in = 4'd1;
        tick();
        n_checks++;
        if (fobs !== 8'b0001_0000) begin n_fail++; $display("FAIL sat_load: got %b want %b", fobs, 8'b0001_0000); end
        load = 0; clr_ovf = 0; en = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (fobs !== want[i]) begin n_fail++; $display("FAIL sat_full step %0d: got %b want %b", i, fobs, want[i]); end
            n_checks++;
            if (lobs !== exp_of(ml)) begin n_fail++; $display("FAIL sat_lim step %0d: got %b want %b", i, lobs, exp_of(ml)); end
        end
        en = 0; clr_ovf = 1;
        tick();
        n_checks++;
        if (f_ovf !== 1'b0) begin n_fail++; $display("FAIL sat_clr: got %b want 0", f_ovf); end
        en = 1;
        tick();
        n_checks++;
        if (f_ovf !== 1'b1) begin n_fail++; $display("FAIL sat_set_wins: got %b want 1", f_ovf); end
        en = 0;
        tick();
    endtask

    task automatic test_oneshot();
        logic [7:0] want [6];
        want = '{8'b0111_0010, 8'b1000_0010, 8'b1001_0010,
                 8'b1010_1010, 8'b1010_0001, 8'b1010_0001};
        mode = 2'd2; up_dn = 1; en = 1; load = 0; clr_ovf = 1;
        tick();
        n_checks++;
        if (lobs !== 8'b0000_0000) begin n_fail++; $display("FAIL os_idle_block: got %b want %b", lobs, 8'b0); end
        clr_ovf = 0; load = 1; data_in = 4'd7;
        for (int i = 0; i < 6; i++) begin
            tick();
            load = 0;
            n_checks++;
            if (lobs !== want[i]) begin n_fail++; $display("FAIL os_lim step %0d: got %b want %b", i, lobs, want[i]); end
            n_checks++;
            if (fobs !== exp_of(mf)) begin n_fail++; $display("FAIL os_full step %0d: got %b want %b", i, fobs, exp_of(mf)); end
        end
        load = 1; data_in = 4'd3;
        tick();
        load = 0;
        n_checks++;
        if (lobs !== 8'b0011_0010) begin n_fail++; $display("FAIL os_rearm: got %b want %b", lobs, 8'b0011_0010); end
        repeat (8) tick();
        n_checks++;
        if (lobs !== 8'b1010_0001) begin n_fail++; $display("FAIL os_done2: got %b want %b", lobs, 8'b1010_0001); end
        mode = 2'd0; en = 0;
        tick();
        n_checks++;
        if (lobs !== 8'b1010_0000) begin n_fail++; $display("FAIL os_exit: got %b want %b", lobs, 8'b1010_0000); end
    endtask

    task automatic test_load_priority();
        mode = 2'd0; up_dn = 1; en = 1; clr_ovf = 1; load = 1; data_in = 4'd5;
        tick();
        n_checks++;
        if (fobs !== 8'b0101_0000 || lobs !== 8'b0101_0000)
            begin n_fail++; $display("FAIL load_wins: got %b/%b want %b", fobs, lobs, 8'b0101_0000); end
        data_in = 4'd15;
        tick();
        n_checks++;
        if (fobs !== 8'b1111_0000) begin n_fail++; $display("FAIL load15_full: got %b want %b", fobs, 8'b1111_0000); end
        n_checks++;
        if (lobs !== 8'b1010_0000) begin n_fail++; $display("FAIL load_clamp: got %b want %b", lobs, 8'b1010_0000); end
        load = 0; en = 0; clr_ovf = 0;
    endtask

    task automatic test_dir_toggle();
        int want [4];
        want = '{6, 5, 6, 5};
        mode = 2'd0; clr_ovf = 1; load = 1; data_in = 4'd5; en = 0;
        tick();
        load = 0; clr_ovf = 0; en = 1;
        for (int i = 0; i < 4; i++) begin
            up_dn = (i % 2 == 0);
            tick();
            n_checks++;
            if (fobs !== {4'(want[i]), 4'b0000})
                begin n_fail++; $display("FAIL toggle_full step %0d: got %b want %b", i, fobs, {4'(want[i]), 4'b0000}); end
            n_checks++;
            if (lobs !== {4'(want[i]), 4'b0000})
                begin n_fail++; $display("FAIL toggle_lim step %0d: got %b want %b", i, lobs, {4'(want[i]), 4'b0000}); end
        end
        en = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            load    = ($urandom_range(0, 7) == 0);
            en      = ($urandom_range(0, 3) != 0);
            up_dn   = 1'($urandom_range(0, 1));
            mode    = 2'($urandom_range(0, 3));
            clr_ovf = ($urandom_range(0, 7) == 0);
            data_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) begin
                rst = 1'b0;
                #2 rst = 1'b1;
                mf = mreset(); ml = mreset();
            end
            tick();
            n_checks++;
            if (fobs !== exp_of(mf)) begin n_fail++; $display("FAIL rand_full cyc %0d: got %b want %b", i, fobs, exp_of(mf)); end
            n_checks++;
            if (lobs !== exp_of(ml)) begin n_fail++; $display("FAIL rand_lim cyc %0d: got %b want %b", i, lobs, exp_of(ml)); end
        end
    endtask

    initial begin
        mf = mreset();
        ml = mreset();
        test_reset();
        test_wrap();
        test_sat();
        test_oneshot();
        test_load_priority();
        test_dir_toggle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
